// File: rtl/sensor_framer_if.sv
// Sensor framer bus: sample input side, transmitter handshake side, status.
interface sensor_framer_if;
    logic [7:0] temp_data;
    logic [7:0] light_data;
    logic       sample_valid;
    logic       tx_busy;
    logic       status_clr;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       frame_busy;
    logic       frame_done;
    logic       overrun;
    logic       tx_err;

    // Framer side
    modport master (
        input  temp_data, light_data, sample_valid, tx_busy, status_clr,
        output tx_data, tx_start, frame_busy, frame_done, overrun, tx_err
    );

    // Sensor / transmitter / host side
    modport slave (
        output temp_data, light_data, sample_valid, tx_busy, status_clr,
        input  tx_data, tx_start, frame_busy, frame_done, overrun, tx_err
    );
endinterface

// File: rtl/sensor_framer.sv
// Packs temp/light samples into 4-byte frames (HEADER, temp, light, checksum)
// and feeds them byte by byte to a start/busy handshaked serial transmitter.
module sensor_framer #(
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    sensor_framer_if.master bus
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_pend_temp, r_pend_light;
    logic            r_pend_valid;
    logic [7:0]      r_frm_temp, r_frm_light;
    logic [1:0]      r_idx;
    logic [TW-1:0]   r_tmo;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic            r_frame_done;
    logic            r_overrun;
    logic            r_tx_err;

    logic            w_load;
    logic            w_timeout;
    logic            w_last;
    logic [7:0]      w_chk;
    logic [7:0]      w_byte;

    assign w_load    = (r_state == IDLE) && r_pend_valid;
    assign w_timeout = (r_state == WAIT_ACK) && !bus.tx_busy &&
                       (r_tmo == TW'(ACK_TIMEOUT - 1));
    assign w_last    = (r_state == WAIT_DONE) && !bus.tx_busy && (r_idx == 2'd3);
    assign w_chk     = HEADER + r_frm_temp + r_frm_light;

    // Byte selected by the current frame index
    always_comb begin
        w_byte = HEADER;
        case (r_idx)
            2'd0: w_byte = HEADER;
            2'd1: w_byte = r_frm_temp;
            2'd2: w_byte = r_frm_light;
            2'd3: w_byte = w_chk;
            default: w_byte = HEADER;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_load) w_state_nxt = SEND;
            SEND:      w_state_nxt = WAIT_ACK;
            WAIT_ACK:  if (bus.tx_busy) w_state_nxt = WAIT_DONE;
                       else if (w_timeout) w_state_nxt = IDLE;
            WAIT_DONE: if (!bus.tx_busy) w_state_nxt = (r_idx == 2'd3) ? IDLE : SEND;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // One-deep pending buffer; a new sample always lands here, a load drains it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_temp  <= 8'h00;
            r_pend_light <= 8'h00;
            r_pend_valid <= 1'b0;
        end else if (bus.sample_valid) begin
            r_pend_temp  <= bus.temp_data;
            r_pend_light <= bus.light_data;
            r_pend_valid <= 1'b1;
        end else if (w_load) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Frame capture and byte index; load copies the old pending sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frm_temp  <= 8'h00;
            r_frm_light <= 8'h00;
            r_idx       <= 2'd0;
        end else if (w_load) begin
            r_frm_temp  <= r_pend_temp;
            r_frm_light <= r_pend_light;
            r_idx       <= 2'd0;
        end else if (r_state == WAIT_DONE && !bus.tx_busy && r_idx != 2'd3) begin
            r_idx       <= r_idx + 2'd1;
        end
    end

    // Ack timeout counter: held at zero outside WAIT_ACK, saturates inside
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          r_tmo <= '0;
        else if (r_state != WAIT_ACK)      r_tmo <= '0;
        else if (r_tmo != TW'(ACK_TIMEOUT)) r_tmo <= r_tmo + 1'b1;
    end

    // Registered transmitter outputs and completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_data    <= 8'h00;
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_state == SEND) r_tx_data <= w_byte;
            r_tx_start   <= (r_state == SEND);
            r_frame_done <= w_last;
        end
    end

    // Sticky status flags; a set event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
            r_tx_err  <= 1'b0;
        end else begin
            if (bus.sample_valid && r_pend_valid && !w_load) r_overrun <= 1'b1;
            else if (bus.status_clr)                        r_overrun <= 1'b0;
            if (w_timeout)                                  r_tx_err  <= 1'b1;
            else if (bus.status_clr)                        r_tx_err  <= 1'b0;
        end
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.tx_start   = r_tx_start;
    assign bus.frame_busy = (r_state != IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.overrun    = r_overrun;
    assign bus.tx_err     = r_tx_err;
endmodule
